// File: rtl/riscv_pkg.sv
// RV32I decode types shared by the decode stage and its immediate generator.
// Optional build macro: DECODE_ILLEGAL_EN adds the illegal flag to the ID/EX bundle.
package riscv_pkg;

    localparam int unsigned DATAWIDTH  = 32;
    localparam int unsigned REG_AWIDTH = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_SRL   = 4'b0111,
        ALU_SLL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_PASSB = 4'b1111
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b010,
        BR_BGE  = 3'b011,
        BR_BLTU = 3'b100,
        BR_BGEU = 3'b101,
        BR_NONE = 3'b111
    } branch_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // Decoded ID/EX payload handed to the execute stage.
    typedef struct packed {
        logic [DATAWIDTH-1:0]  pc;
        logic [REG_AWIDTH-1:0] rs1;
        logic [REG_AWIDTH-1:0] rs2;
        logic [REG_AWIDTH-1:0] rd;
        logic [DATAWIDTH-1:0]  imm;
        alu_op_e               alu_op;
        branch_op_e            br_op;
        logic                  src_a;
        logic                  src_b;
        result_src_e           result_src;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic                  jump;
        logic                  jump_reg;
        logic [2:0]            mem_size;
`ifdef DECODE_ILLEGAL_EN
        logic                  illegal;
`endif
    } id_ex_t;

    // Empty bundle: everything zero except "no branch".
    function automatic id_ex_t bundle_reset();
        id_ex_t b;
        b       = '0;
        b.br_op = BR_NONE;
        return b;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: selects the RV32I immediate format from the opcode.
// Ports: instr (instruction word) -> imm (sign-extended immediate, 0 for R-type/unknown).
module imm_gen
    import riscv_pkg::*;
(
    input  logic [DATAWIDTH-1:0] instr,
    output logic [DATAWIDTH-1:0] imm
);

    logic sgn;
    assign sgn = instr[31];

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{sgn}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{sgn}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{sgn}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{sgn}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: decodes {instr, pc} from fetch into a registered
// ID/EX bundle, inserts one bubble on load-use hazards and honours EX flushes.
// Ports: clk_i/rst_i (sync active-high), instr_i/pc_i/in_valid_i/in_ready_o (fetch side),
// flush_i, out_ready_i/out_valid_o plus the bundle fields (EX side).
// Optional build macro: DECODE_ILLEGAL_EN adds illegal_o for unknown encodings.
module decode_stage
    import riscv_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATAWIDTH-1:0]  instr_i,
    input  logic [DATAWIDTH-1:0]  pc_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  flush_i,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output logic [DATAWIDTH-1:0]  pc_o,
    output logic [REG_AWIDTH-1:0] rs1_o,
    output logic [REG_AWIDTH-1:0] rs2_o,
    output logic [REG_AWIDTH-1:0] rd_o,
    output logic [DATAWIDTH-1:0]  imm_o,
    output logic [3:0]            ALUctrl_o,
    output logic [2:0]            BranchCtrl_o,
    output logic                  ALUSrcA_o,
    output logic                  ALUSrcB_o,
    output logic [1:0]            ResultSrc_o,
    output logic                  MemRead_o,
    output logic                  MemWrite_o,
    output logic                  RegWrite_o,
    output logic                  Jump_o,
    output logic                  JumpReg_o,
    output logic [2:0]            MemSize_o
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic                  illegal_o
`endif
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_AWIDTH-1:0] rs1_f;
    logic [REG_AWIDTH-1:0] rs2_f;
    logic [REG_AWIDTH-1:0] rd_f;
    logic [DATAWIDTH-1:0]  imm;

    assign opcode = instr_i[6:0];
    assign rd_f   = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1_f  = instr_i[19:15];
    assign rs2_f  = instr_i[24:20];
    assign funct7 = instr_i[31:25];

    imm_gen u_imm_gen (
        .instr (instr_i),
        .imm   (imm)
    );

    id_ex_t bundle_q;
    logic   valid_q;
    id_ex_t dec;
    logic   legal;

    // Decode table; illegal encodings collapse to a NOP bundle.
    always_comb begin
        dec    = bundle_reset();
        legal  = 1'b1;
        dec.pc  = pc_i;
        dec.imm = imm;
        case (opcode)
            OPC_OP: begin
                dec.rs1       = rs1_f;
                dec.rs2       = rs2_f;
                dec.rd        = rd_f;
                dec.reg_write = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  dec.alu_op = ALU_SLL;
                    3'b010:  dec.alu_op = ALU_SLT;
                    3'b011:  dec.alu_op = ALU_SLTU;
                    3'b100:  dec.alu_op = ALU_XOR;
                    3'b101:  dec.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
                legal = (funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                dec.rs1       = rs1_f;
                dec.rd        = rd_f;
                dec.reg_write = 1'b1;
                dec.src_b     = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_ADD;
                    3'b001: begin
                        dec.alu_op = ALU_SLL;
                        legal      = (funct7 == 7'h00);
                    end
                    3'b010:  dec.alu_op = ALU_SLT;
                    3'b011:  dec.alu_op = ALU_SLTU;
                    3'b100:  dec.alu_op = ALU_XOR;
                    3'b101: begin
                        dec.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                        legal      = (funct7 == 7'h00) || (funct7 == 7'h20);
                    end
                    3'b110:  dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            OPC_LOAD: begin
                dec.rs1        = rs1_f;
                dec.rd         = rd_f;
                dec.reg_write  = 1'b1;
                dec.src_b      = 1'b1;
                dec.mem_read   = 1'b1;
                dec.result_src = RES_MEM;
                dec.mem_size   = funct3;
                legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b101);
            end
            OPC_STORE: begin
                dec.rs1       = rs1_f;
                dec.rs2       = rs2_f;
                dec.src_b     = 1'b1;
                dec.mem_write = 1'b1;
                dec.mem_size  = funct3;
                legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            end
            OPC_BRANCH: begin
                dec.rs1    = rs1_f;
                dec.rs2    = rs2_f;
                dec.alu_op = ALU_SUB;
                case (funct3)
                    3'b000:  dec.br_op = BR_BEQ;
                    3'b001:  dec.br_op = BR_BNE;
                    3'b100:  dec.br_op = BR_BLT;
                    3'b101:  dec.br_op = BR_BGE;
                    3'b110:  dec.br_op = BR_BLTU;
                    3'b111:  dec.br_op = BR_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                dec.rd        = rd_f;
                dec.reg_write = 1'b1;
                dec.src_b     = 1'b1;
                dec.alu_op    = ALU_PASSB;
            end
            OPC_AUIPC: begin
                dec.rd        = rd_f;
                dec.reg_write = 1'b1;
                dec.src_a     = 1'b1;
                dec.src_b     = 1'b1;
            end
            OPC_JAL: begin
                dec.rd         = rd_f;
                dec.reg_write  = 1'b1;
                dec.src_a      = 1'b1;
                dec.src_b      = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = RES_PC4;
            end
            OPC_JALR: begin
                dec.rs1        = rs1_f;
                dec.rd         = rd_f;
                dec.reg_write  = 1'b1;
                dec.src_b      = 1'b1;
                dec.jump       = 1'b1;
                dec.jump_reg   = 1'b1;
                dec.result_src = RES_PC4;
                legal          = (funct3 == 3'b000);
            end
            default: legal = 1'b0;
        endcase
        if (dec.rd == '0) begin
            dec.reg_write = 1'b0;
        end
        if (!legal) begin
            dec    = bundle_reset();
            dec.pc = pc_i;
`ifdef DECODE_ILLEGAL_EN
            dec.illegal = 1'b1;
`endif
        end
    end

    // Load-use hazard: operand register classes follow the opcode format.
    logic uses_rs1;
    logic uses_rs2;
    logic hazard;
    logic adv;

    assign uses_rs1 = (opcode == OPC_OP) || (opcode == OPC_OP_IMM) || (opcode == OPC_LOAD) ||
                      (opcode == OPC_STORE) || (opcode == OPC_BRANCH) || (opcode == OPC_JALR);
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    assign hazard = valid_q && bundle_q.mem_read && (bundle_q.rd != '0) && in_valid_i &&
                    ((uses_rs1 && (rs1_f == bundle_q.rd)) || (uses_rs2 && (rs2_f == bundle_q.rd)));
    assign adv        = !valid_q || out_ready_i;
    assign in_ready_o = flush_i || (adv && !hazard);

    // Bundle register: flush > hazard bubble > load/drain > hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            bundle_q <= bundle_reset();
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (hazard) begin
            if (out_ready_i) begin
                valid_q  <= 1'b0;
                bundle_q <= bundle_reset();
            end
        end else if (adv) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                bundle_q <= dec;
            end
        end
    end

    assign out_valid_o  = valid_q;
    assign pc_o         = bundle_q.pc;
    assign rs1_o        = bundle_q.rs1;
    assign rs2_o        = bundle_q.rs2;
    assign rd_o         = bundle_q.rd;
    assign imm_o        = bundle_q.imm;
    assign ALUctrl_o    = bundle_q.alu_op;
    assign BranchCtrl_o = bundle_q.br_op;
    assign ALUSrcA_o    = bundle_q.src_a;
    assign ALUSrcB_o    = bundle_q.src_b;
    assign ResultSrc_o  = bundle_q.result_src;
    assign MemRead_o    = bundle_q.mem_read;
    assign MemWrite_o   = bundle_q.mem_write;
    assign RegWrite_o   = bundle_q.reg_write;
    assign Jump_o       = bundle_q.jump;
    assign JumpReg_o    = bundle_q.jump_reg;
    assign MemSize_o    = bundle_q.mem_size;
`ifdef DECODE_ILLEGAL_EN
    assign illegal_o    = bundle_q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios then randomized traffic
// against an instruction-level reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] pc_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [31:0] imm_o;
    logic [3:0]  alu_o;
    logic [2:0]  br_o;
    logic        sa_o, sb_o;
    logic [1:0]  res_o;
    logic        mr_o, mw_o, rw_o, j_o, jr_o;
    logic [2:0]  ms_o;
`ifdef DECODE_ILLEGAL_EN
    logic        ill_o;
`endif

    always #5 clk = ~clk;

    decode_stage dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .instr_i      (instr),
        .pc_i         (pc_in),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .flush_i      (flush),
        .out_ready_i  (out_ready),
        .out_valid_o  (out_valid),
        .pc_o         (pc_o),
        .rs1_o        (rs1_o),
        .rs2_o        (rs2_o),
        .rd_o         (rd_o),
        .imm_o        (imm_o),
        .ALUctrl_o    (alu_o),
        .BranchCtrl_o (br_o),
        .ALUSrcA_o    (sa_o),
        .ALUSrcB_o    (sb_o),
        .ResultSrc_o  (res_o),
        .MemRead_o    (mr_o),
        .MemWrite_o   (mw_o),
        .RegWrite_o   (rw_o),
        .Jump_o       (j_o),
        .JumpReg_o    (jr_o),
        .MemSize_o    (ms_o)
`ifdef DECODE_ILLEGAL_EN
        ,
        .illegal_o    (ill_o)
`endif
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [2:0]  br;
        logic        sa, sb;
        logic [1:0]  res;
        logic        mr, mw, rw, j, jr;
        logic [2:0]  ms;
        logic        ill;
    } exp_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t m;
    logic accepted;
    logic last_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e    = '0;
        e.br = 3'b111;
        return e;
    endfunction

    function automatic logic uses1(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses2(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011, 7'b0100011, 7'b1100011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level reference: ALU op tables by funct3, immediates by signed arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t         e;
        logic [2:0]   f3;
        logic [6:0]   f7;
        logic         ok;
        int           v;
        logic [3:0]   alu_tab [8];
        logic [2:0]   br_tab  [8];
        alu_tab = '{4'd0, 4'd8, 4'd5, 4'd6, 4'd4, 4'd7, 4'd3, 4'd2};
        br_tab  = '{3'd0, 3'd1, 3'd7, 3'd7, 3'd2, 3'd3, 3'd4, 3'd5};
        f3 = ins[14:12];
        f7 = ins[31:25];
        ok = 1'b1;
        e  = reset_exp();
        e.pc = pc;
        case (ins[6:0])
            7'b0110011: begin // R-type
                e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.rw = 1'b1;
                e.alu = alu_tab[f3];
                if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'd1;
                if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd9;
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            7'b0010011: begin // I-type ALU
                e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.rw = 1'b1; e.sb = 1'b1;
                v = $signed(ins[31:20]); e.imm = v;
                e.alu = alu_tab[f3];
                if (f3 == 3'd5 && f7 == 7'h20) e.alu = 4'd9;
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            end
            7'b0000011: begin // load
                e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.rw = 1'b1; e.sb = 1'b1;
                e.mr = 1'b1; e.res = 2'b01; e.ms = f3;
                v = $signed(ins[31:20]); e.imm = v;
                ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
            end
            7'b0100011: begin // store
                e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.sb = 1'b1; e.mw = 1'b1; e.ms = f3;
                v = $signed({ins[31:25], ins[11:7]}); e.imm = v;
                ok = (f3 < 3'd3);
            end
            7'b1100011: begin // branch
                e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.alu = 4'd1; e.br = br_tab[f3];
                v = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2; e.imm = v;
                ok = (f3 != 3'd2) && (f3 != 3'd3);
            end
            7'b0110111: begin // lui
                e.rd = ins[11:7]; e.rw = 1'b1; e.sb = 1'b1; e.alu = 4'hF;
                e.imm = ins & 32'hFFFF_F000;
            end
            7'b0010111: begin // auipc
                e.rd = ins[11:7]; e.rw = 1'b1; e.sa = 1'b1; e.sb = 1'b1;
                e.imm = ins & 32'hFFFF_F000;
            end
            7'b1101111: begin // jal
                e.rd = ins[11:7]; e.rw = 1'b1; e.sa = 1'b1; e.sb = 1'b1; e.j = 1'b1; e.res = 2'b10;
                v = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2; e.imm = v;
            end
            7'b1100111: begin // jalr
                e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.rw = 1'b1; e.sb = 1'b1;
                e.j = 1'b1; e.jr = 1'b1; e.res = 2'b10;
                v = $signed(ins[31:20]); e.imm = v;
                ok = (f3 == 3'd0);
            end
            default: ok = 1'b0;
        endcase
        if (e.rd == 5'd0) e.rw = 1'b0;
        if (!ok) begin
            e     = reset_exp();
            e.pc  = pc;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(m.valid));
        check("pc", pc_o, m.pc);
        check("rs1", 32'(rs1_o), 32'(m.rs1));
        check("rs2", 32'(rs2_o), 32'(m.rs2));
        check("rd", 32'(rd_o), 32'(m.rd));
        check("imm", imm_o, m.imm);
        check("alu", 32'(alu_o), 32'(m.alu));
        check("branch", 32'(br_o), 32'(m.br));
        check("src_a", 32'(sa_o), 32'(m.sa));
        check("src_b", 32'(sb_o), 32'(m.sb));
        check("result_src", 32'(res_o), 32'(m.res));
        check("mem_read", 32'(mr_o), 32'(m.mr));
        check("mem_write", 32'(mw_o), 32'(m.mw));
        check("reg_write", 32'(rw_o), 32'(m.rw));
        check("jump", 32'(j_o), 32'(m.j));
        check("jump_reg", 32'(jr_o), 32'(m.jr));
        check("mem_size", 32'(ms_o), 32'(m.ms));
`ifdef DECODE_ILLEGAL_EN
        check("illegal", 32'(ill_o), 32'(m.ill));
`endif
    endtask

    // One clock: drive inputs, check in_ready, advance the model, check outputs.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic adv, hz, rdy;
        exp_t d;
        in_valid  = iv;
        instr     = ins;
        pc_in     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        adv = !m.valid || ordy;
        hz  = m.valid && m.mr && (m.rd != 5'd0) && iv &&
              ((uses1(ins) && ins[19:15] == m.rd) || (uses2(ins) && ins[24:20] == m.rd));
        rdy = fl || (adv && !hz);
        last_ready = in_ready;
        check("in_ready", 32'(in_ready), 32'(rdy));
        accepted = iv && rdy;
        if (fl) begin
            m.valid = 1'b0;
        end else if (hz) begin
            if (ordy) m = reset_exp();
        end else if (adv) begin
            if (iv) begin
                d       = ref_decode(ins, pc);
                d.valid = 1'b1;
                m       = d;
            end else begin
                m.valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [11:0] i12;
        logic [19:0] u20;
        logic [2:0]  ld_f3 [5];
        logic [2:0]  br_f3 [6];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        rd  = 5'($urandom_range(0, 3));
        r1  = 5'($urandom_range(0, 3));
        r2  = 5'($urandom_range(0, 3));
        f3  = 3'($urandom_range(0, 7));
        i12 = 12'($urandom);
        u20 = 20'($urandom);
        case ($urandom_range(0, 11))
            0: return {((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                       r2, r1, f3, rd, 7'b0110011};
            1: begin
                if (f3 == 3'd1) i12[11:5] = 7'h00;
                if (f3 == 3'd5) i12[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return {i12, r1, f3, rd, 7'b0010011};
            end
            2, 11: return {i12, r1, ld_f3[$urandom_range(0, 4)], rd, 7'b0000011};
            3: return {i12[11:5], r2, r1, 3'($urandom_range(0, 2)), i12[4:0], 7'b0100011};
            4: return {i12[11:5], r2, r1, br_f3[$urandom_range(0, 5)], i12[4:0], 7'b1100011};
            5: return {u20, rd, 7'b0110111};
            6: return {u20, rd, 7'b0010111};
            7: return {u20, rd, 7'b1101111};
            8: return {i12, r1, 3'd0, rd, 7'b1100111};
            9: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] cur, cur_pc;
        logic        iv, ordy, fl;
        rst = 1'b1; instr = '0; pc_in = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        m = reset_exp();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
        check("reset_branch", 32'(br_o), 32'd7);

        // addi x1,x2,5
        step(1'b1, 32'h0051_0093, 32'h100, 1'b1, 1'b0);
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_alu", 32'(alu_o), 32'd0);
        check("addi_srcb", 32'(sb_o), 32'd1);
        check("addi_imm", imm_o, 32'd5);
        check("addi_rd", 32'(rd_o), 32'd1);
        check("addi_rw", 32'(rw_o), 32'd1);

        // beq x1,x2,-8
        step(1'b1, 32'hFE20_8CE3, 32'h104, 1'b1, 1'b0);
        check("beq_br", 32'(br_o), 32'd0);
        check("beq_alu", 32'(alu_o), 32'd1);
        check("beq_imm", imm_o, 32'hFFFF_FFF8);
        check("beq_rw", 32'(rw_o), 32'd0);

        // lw x5,0(x1) then add x6,x5,x5: one bubble
        step(1'b1, 32'h0000_A283, 32'h108, 1'b1, 1'b0);
        step(1'b1, 32'h0052_8333, 32'h10C, 1'b1, 1'b0);
        check("lu_stall_ready", 32'(last_ready), 32'd0);
        check("lu_bubble", 32'(out_valid), 32'd0);
        step(1'b1, 32'h0052_8333, 32'h10C, 1'b1, 1'b0);
        check("lu_ready", 32'(last_ready), 32'd1);
        check("lu_add_rd", 32'(rd_o), 32'd6);
        check("lu_add_valid", 32'(out_valid), 32'd1);

        // backpressure: hold 3 cycles then release
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0051_0093, 32'h110, 1'b0, 1'b0);
            check("stall_ready", 32'(last_ready), 32'd0);
            check("stall_pc", pc_o, 32'h10C);
        end
        step(1'b1, 32'h0051_0093, 32'h110, 1'b1, 1'b0);
        check("release_pc", pc_o, 32'h110);

        // flush with valid bundle and valid input
        step(1'b1, 32'h0052_8333, 32'h114, 1'b0, 1'b1);
        check("flush_ready", 32'(last_ready), 32'd1);
        check("flush_valid", 32'(out_valid), 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("flush_dropped", 32'(out_valid), 32'd0);

        // all-ones encoding
        step(1'b1, 32'hFFFF_FFFF, 32'h118, 1'b1, 1'b0);
        check("ill_valid", 32'(out_valid), 32'd1);
        check("ill_rw", 32'(rw_o), 32'd0);
        check("ill_br", 32'(br_o), 32'd7);
`ifdef DECODE_ILLEGAL_EN
        check("ill_flag", 32'(ill_o), 32'd1);
`endif

        // randomized traffic
        cur    = gen_instr();
        cur_pc = 32'h1000;
        for (int c = 0; c < 800; c++) begin
            iv   = ($urandom_range(0, 9) < 8);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            step(iv, cur, cur_pc, ordy, fl);
            if (accepted) begin
                cur    = gen_instr();
                cur_pc = cur_pc + 32'd4;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
